// File: rtl/fp32_pkg.sv
// fp32_pkg
//   Shared definitions for the FP32 multiplier datapath.
//   Contents:
//     - field widths EXP_W, MAN_W and the all-ones exponent EXP_MAX
//     - product class encoding fp_cls_t (CLS_NORMAL, CLS_ZERO, CLS_INF, CLS_NAN)
//     - fp_unpacked_t: one operand split into {sign, exp, man}
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } fp_cls_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_unpacked_t;

endpackage

// File: rtl/fp32_classify.sv
// fp32_classify
//   Purely combinational unpack/classify of one packed FP32 operand.
//   Denormals are flushed to zero (exp and fraction forced to 0, sign kept).
//   Ports:
//     op        in  32  packed FP32 operand
//     is_zero   out 1   operand is zero after flush (exp == 0)
//     is_denorm out 1   operand was denormal (exp == 0, fraction != 0)
//     is_inf    out 1   infinity (only with FP_SPECIAL_CASE_EN, else 0)
//     is_nan    out 1   NaN      (only with FP_SPECIAL_CASE_EN, else 0)
//     sign      out 1   sign bit
//     exp       out 8   biased exponent after flush
//     man       out 23  fraction after flush, no hidden bit
//   Configuration macro: FP_SPECIAL_CASE_EN. When undefined, exponent 255 is
//   an ordinary exponent and is_inf/is_nan are tied low.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0]      op,
  output logic             is_zero,
  output logic             is_denorm,
  output logic             is_inf,
  output logic             is_nan,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [MAN_W-1:0] man
);

  logic [EXP_W-1:0] raw_exp;
  logic [MAN_W-1:0] raw_man;

  assign raw_exp   = op[30:23];
  assign raw_man   = op[22:0];

  assign is_denorm = (raw_exp == '0) && (raw_man != '0);
  // A denormal already has exp 0, so only the fraction needs forcing.
  assign is_zero   = (raw_exp == '0);
  assign sign      = op[31];
  assign exp       = raw_exp;
  assign man       = is_denorm ? '0 : raw_man;

`ifdef FP_SPECIAL_CASE_EN
  assign is_inf    = (raw_exp == EXP_MAX) && (raw_man == '0);
  assign is_nan    = (raw_exp == EXP_MAX) && (raw_man != '0);
`else
  assign is_inf    = 1'b0;
  assign is_nan    = 1'b0;
`endif

endmodule

// File: rtl/fp32_mul_unpack.sv
// fp32_mul_unpack
//   Input stage of the FP32 multiplier: 2-stage elastic pipeline that
//   registers an operand pair (stage A), then unpacks, flushes denormals and
//   classifies the product (stage B) for the downstream multiply core.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     in_valid/in_ready        operand pair handshake
//     in_x, in_y               packed FP32 operands
//     out_valid/out_ready      unpacked field handshake
//     sign_x/y, exp_x/y        sign, biased exponent (0 after flush)
//     mantissa_x/y             fraction without hidden bit (0 after flush)
//     out_cls                  0 normal, 1 zero, 2 inf, 3 NaN
//     cnt_clr                  synchronous clear of denorm_cnt (wins over increment)
//     denorm_cnt               saturating count of flushed denormal operands
//   Configuration macro: FP_SPECIAL_CASE_EN (inf/NaN classification, handled
//   inside fp32_classify; inf/NaN flags are tied low when undefined).
module fp32_mul_unpack
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_x,
  output logic        sign_y,
  output logic [7:0]  exp_x,
  output logic [7:0]  exp_y,
  output logic [22:0] mantissa_x,
  output logic [22:0] mantissa_y,
  output logic [1:0]  out_cls,
  input  logic        cnt_clr,
  output logic [15:0] denorm_cnt
);

  logic             b_ready;
  logic             accept_p0;
  logic             load_p1;

  logic             vld_p0_q, vld_p0_d;
  logic [31:0]      x_p0_q, x_p0_d;
  logic [31:0]      y_p0_q, y_p0_d;

  logic             zero_x, den_x, inf_x, nan_x, sx;
  logic             zero_y, den_y, inf_y, nan_y, sy;
  logic [EXP_W-1:0] ex, ey;
  logic [MAN_W-1:0] mx, my;
  fp_cls_t          cls_s;
  logic [1:0]       n_den;

  logic             vld_p1_q, vld_p1_d;
  fp_unpacked_t     fx_p1_q, fx_p1_d;
  fp_unpacked_t     fy_p1_q, fy_p1_d;
  fp_cls_t          cls_p1_q, cls_p1_d;
  logic [15:0]      cnt_q, cnt_d;

  function automatic logic [15:0] sat_add_cnt(input logic [15:0] acc,
                                              input logic [1:0]  inc);
    logic [16:0] sum;
    sum = {1'b0, acc} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Ready depends only on registered valid bits and out_ready, never on in_valid.
  assign b_ready   = !vld_p1_q || out_ready;
  assign in_ready  = !vld_p0_q || b_ready;
  assign accept_p0 = in_valid && in_ready;
  assign load_p1   = vld_p0_q && b_ready;

  // ---- stage A -> stage B boundary: unpack and classify ----
  fp32_classify u_cls_x (
    .op        (x_p0_q),
    .is_zero   (zero_x),
    .is_denorm (den_x),
    .is_inf    (inf_x),
    .is_nan    (nan_x),
    .sign      (sx),
    .exp       (ex),
    .man       (mx)
  );

  fp32_classify u_cls_y (
    .op        (y_p0_q),
    .is_zero   (zero_y),
    .is_denorm (den_y),
    .is_inf    (inf_y),
    .is_nan    (nan_y),
    .sign      (sy),
    .exp       (ey),
    .man       (my)
  );

  always_comb begin
    cls_s = CLS_NORMAL;
    if (nan_x || nan_y || (inf_x && zero_y) || (zero_x && inf_y)) begin
      cls_s = CLS_NAN;
    end else if (inf_x || inf_y) begin
      cls_s = CLS_INF;
    end else if (zero_x || zero_y) begin
      cls_s = CLS_ZERO;
    end
  end

  assign n_den = {1'b0, den_x} + {1'b0, den_y};

  always_comb begin
    vld_p0_d = vld_p0_q;
    x_p0_d   = x_p0_q;
    y_p0_d   = y_p0_q;
    vld_p1_d = vld_p1_q;
    fx_p1_d  = fx_p1_q;
    fy_p1_d  = fy_p1_q;
    cls_p1_d = cls_p1_q;
    cnt_d    = cnt_q;

    if (in_ready) vld_p0_d = in_valid;
    if (accept_p0) begin
      x_p0_d = in_x;
      y_p0_d = in_y;
    end

    if (b_ready) vld_p1_d = vld_p0_q;
    if (load_p1) begin
      fx_p1_d  = {sx, ex, mx};
      fy_p1_d  = {sy, ey, my};
      cls_p1_d = cls_s;
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (load_p1) begin
      cnt_d = sat_add_cnt(cnt_q, n_den);
    end
  end

  // ---- stage A registers ----
  always_ff @(posedge clk) begin
    if (rst) vld_p0_q <= 1'b0;
    else     vld_p0_q <= vld_p0_d;
  end

  always_ff @(posedge clk) begin
    x_p0_q <= x_p0_d;
    y_p0_q <= y_p0_d;
  end

  // ---- stage B registers (fields cleared on reset so outputs read 0) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      fx_p1_q  <= '0;
      fy_p1_q  <= '0;
      cls_p1_q <= CLS_NORMAL;
      cnt_q    <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      fx_p1_q  <= fx_p1_d;
      fy_p1_q  <= fy_p1_d;
      cls_p1_q <= cls_p1_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = vld_p1_q;
  assign sign_x     = fx_p1_q.sign;
  assign exp_x      = fx_p1_q.exp;
  assign mantissa_x = fx_p1_q.man;
  assign sign_y     = fy_p1_q.sign;
  assign exp_y      = fy_p1_q.exp;
  assign mantissa_y = fy_p1_q.man;
  assign out_cls    = cls_p1_q;
  assign denorm_cnt = cnt_q;

endmodule

// File: tb/tb_fp32_mul_unpack.sv
// Testbench for fp32_mul_unpack: directed vectors plus randomized traffic
// checked against a behavioural model and an expected-output queue.
// Honours FP_SPECIAL_CASE_EN the same way the design does.
module tb_fp32_mul_unpack;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [31:0] in_x, in_y;
  logic        sign_x, sign_y;
  logic [7:0]  exp_x, exp_y;
  logic [22:0] mantissa_x, mantissa_y;
  logic [1:0]  out_cls;
  logic [15:0] denorm_cnt;

  always #5 clk = ~clk;

  fp32_mul_unpack dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sign_x     (sign_x),
    .sign_y     (sign_y),
    .exp_x      (exp_x),
    .exp_y      (exp_y),
    .mantissa_x (mantissa_x),
    .mantissa_y (mantissa_y),
    .out_cls    (out_cls),
    .cnt_clr    (cnt_clr),
    .denorm_cnt (denorm_cnt)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [65:0] exp_q[$];
  int          cnt_m   = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: {sx, ex, mx, sy, ey, my, cls} from the arithmetic rules.
  function automatic logic [65:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] op[2];
    logic        s[2];
    logic [7:0]  e[2];
    logic [22:0] m[2];
    bit          z[2], inf[2], nan[2];
    logic [1:0]  c;
    op[0] = x;
    op[1] = y;
    for (int i = 0; i < 2; i++) begin
      s[i]   = op[i][31];
      e[i]   = op[i][30:23];
      m[i]   = (e[i] == 8'd0) ? 23'd0 : op[i][22:0];
      z[i]   = (e[i] == 8'd0);
      inf[i] = 1'b0;
      nan[i] = 1'b0;
`ifdef FP_SPECIAL_CASE_EN
      inf[i] = (e[i] == 8'hFF) && (m[i] == 23'd0);
      nan[i] = (e[i] == 8'hFF) && (m[i] != 23'd0);
`endif
    end
    if (nan[0] || nan[1] || (inf[0] && z[1]) || (inf[1] && z[0])) c = 2'd3;
    else if (inf[0] || inf[1])                                  c = 2'd2;
    else if (z[0] || z[1])                                      c = 2'd1;
    else                                                        c = 2'd0;
    return {s[0], e[0], m[0], s[1], e[1], m[1], c};
  endfunction

  function automatic int n_den(input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    if (x[30:23] == 8'd0 && x[22:0] != 23'd0) n++;
    if (y[30:23] == 8'd0 && y[22:0] != 23'd0) n++;
    return n;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return {r[31], 8'h00, 23'd0};
      1:       return {r[31], 8'h00, r[22:0] | 23'd1};
      2:       return {r[31], 8'hFF, 23'd0};
      3:       return {r[31], 8'hFF, r[22:0] | 23'd1};
      default: return r;
    endcase
  endfunction

  // Output monitor: samples mid-cycle after drivers have settled.
  logic [65:0] held;
  bit          stalled = 1'b0;
  initial begin
    logic [65:0] cur;
    forever begin
      @(negedge clk);
      #3;
      cur = {sign_x, exp_x, mantissa_x, sign_y, exp_y, mantissa_y, out_cls};
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) check("hold", {out_valid, cur}, {1'b1, held});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("out_pending", exp_q.size(), 1);
          else                   check("out_data", cur, exp_q.pop_front());
        end
        stalled = out_valid && !out_ready;
        held    = cur;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One cycle of stimulus; acc reports whether the pair is taken at the next edge.
  task automatic drive(input bit v, input logic [31:0] x, input logic [31:0] y,
                       input bit ordy, output bit acc);
    in_valid  = v;
    in_x      = x;
    in_y      = y;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) begin
      exp_q.push_back(model(x, y));
      cnt_m = cnt_m + n_den(x, y);
      if (cnt_m > 65535) cnt_m = 65535;
    end
    step();
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input bit ordy);
    bit acc = 1'b0;
    for (int g = 0; g < 20 && !acc; g++) drive(1'b1, x, y, ordy, acc);
    if (!acc) check("send_accept", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 32'd0, 1'b1, acc);
  endtask

  initial begin
    bit          acc, low_seen;
    int          k;
    logic [31:0] px[5], py[5];

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (3) step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_fields", {sign_x, exp_x, mantissa_x, sign_y, exp_y, mantissa_y, out_cls}, 66'd0);
    check("rst_cnt", denorm_cnt, 16'd0);
    rst = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1'b1);

    // 1.5 x 2.0: two-cycle latency and plain unpack.
    drive(1'b1, 32'h3FC0_0000, 32'h4000_0000, 1'b1, acc);
    check("lat_1edge_vld", out_valid, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, acc);
    check("lat_2edge_vld", out_valid, 1'b1);
    check("t1_sign", {sign_x, sign_y}, 2'b00);
    check("t1_exp", {exp_x, exp_y}, {8'd127, 8'd128});
    check("t1_man", {mantissa_x, mantissa_y}, {23'h40_0000, 23'h00_0000});
    check("t1_cls", out_cls, 2'd0);

    // Two denormals: flushed, zero class, counted.
    drive(1'b1, 32'h0000_0001, 32'h8000_0003, 1'b1, acc);
    drive(1'b0, 32'd0, 32'd0, 1'b1, acc);
    check("t2_exp", {exp_x, exp_y}, 16'd0);
    check("t2_man", {mantissa_x, mantissa_y}, 46'd0);
    check("t2_sign", {sign_x, sign_y}, 2'b01);
    check("t2_cls", out_cls, 2'd1);
    check("t2_cnt", denorm_cnt, 16'd2);

    // Special-value classes.
    drive(1'b1, 32'h7F80_0000, 32'h0000_0000, 1'b1, acc);
    drive(1'b0, 32'd0, 32'd0, 1'b1, acc);
`ifdef FP_SPECIAL_CASE_EN
    check("inf_x_zero_cls", out_cls, 2'd3);
`else
    check("inf_x_zero_cls", out_cls, 2'd1);
`endif
    drive(1'b1, 32'h7FC0_0000, 32'h3F80_0000, 1'b1, acc);
    drive(1'b0, 32'd0, 32'd0, 1'b1, acc);
`ifdef FP_SPECIAL_CASE_EN
    check("nan_x_one_cls", out_cls, 2'd3);
`else
    check("nan_x_one_cls", out_cls, 2'd0);
`endif
    idle(2);

    // Five pairs with out_ready low in cycles 2..6.
    for (int i = 0; i < 5; i++) begin
      px[i] = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      py[i] = {1'b1, 8'($urandom_range(1, 254)), 23'($urandom)};
    end
    k = 0;
    low_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      low_seen |= !in_ready;
      if (k < 5) begin
        drive(1'b1, px[k], py[k], !(c >= 2 && c <= 6), acc);
        if (acc) k++;
      end else begin
        drive(1'b0, 32'd0, 32'd0, 1'b1, acc);
      end
    end
    in_valid = 1'b0;
    check("stream_all_accepted", k, 5);
    check("stream_in_ready_low", low_seen, 1'b1);
    check("stream_drained", exp_q.size(), 0);
    check("stream_cnt", denorm_cnt, 16'(cnt_m));

    // Clear coinciding with a stage-B increment.
    send(32'h0000_0005, 32'h8000_0007, 1'b1);
    cnt_clr = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b1, acc);
    cnt_clr = 1'b0;
    cnt_m = 0;
    idle(2);
    check("clr_wins", denorm_cnt, 16'd0);

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 4) != 0, rand_op(), rand_op(), ($urandom % 3) != 0, acc);
    end
    in_valid = 1'b0;
    idle(5);
    check("rand_drained", exp_q.size(), 0);
    check("rand_cnt", denorm_cnt, 16'(cnt_m));

    // Saturation: clear, preload to 0xFFFE, then +2 and +1 stick at 0xFFFF.
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    cnt_m = 0;
    for (int i = 0; i < 32767; i++) drive(1'b1, 32'h0000_0001, 32'h8000_0001, 1'b1, acc);
    in_valid = 1'b0;
    idle(3);
    check("sat_preload", denorm_cnt, 16'hFFFE);
    send(32'h0000_0002, 32'h0000_0003, 1'b1);
    idle(3);
    check("sat_plus2", denorm_cnt, 16'hFFFF);
    send(32'h0000_0004, 32'h3F80_0000, 1'b1);
    idle(3);
    check("sat_hold", denorm_cnt, 16'hFFFF);

    // Reset with two pairs in flight.
    send(32'h0000_0011, 32'h4040_0000, 1'b0);
    send(32'h4080_0000, 32'h0000_0022, 1'b0);
    check("rst_pre_full", in_ready, 1'b0);
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, acc);
    rst = 1'b0;
    exp_q.delete();
    cnt_m = 0;
    check("rst_mid_vld", out_valid, 1'b0);
    check("rst_mid_rdy", in_ready, 1'b1);
    check("rst_mid_cnt", denorm_cnt, 16'd0);
    idle(4);
    check("rst_no_ghost_vld", out_valid, 1'b0);
    send(32'h3F80_0000, 32'hC000_0000, 1'b1);
    idle(3);
    check("post_rst_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
